multdiv_ctrl: RTL and testbench

- Multicycle signed multiply/divide sequencer that sits beside the single-cycle ALU in the execute stage.
- Accepts a one-cycle start pulse, latches both operands and runs a fixed 32-iteration algorithm: radix-2 Booth for multiply, restoring for divide.
- Returns a one-cycle ready strobe with the result and an exception flag. The pipeline stalls on this strobe.

---
 rtl/multdiv_ctrl_pkg.sv | 19 +
 rtl/md_counter.sv | 40 ++++
 rtl/multdiv_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multicycle multiply/divide sequencer.
//   - DefaultWidth : default operand/result width
//   - AluOpMult/Div: opcodes as they appear in the ALU opcode field
//   - state_e      : sequencer state encoding
package multdiv_ctrl_pkg;

  localparam int unsigned DefaultWidth = 32;

  localparam logic [4:0] AluOpMult = 5'b00110;
  localparam logic [4:0] AluOpDiv  = 5'b00111;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StMulRun = 2'd1,
    StDivRun = 2'd2,
    StDone   = 2'd3
  } state_e;

endpackage

// File: rtl/md_counter.sv
// Iteration counter for the mult/div sequencer: counts 0 .. ITERS-1 and wraps.
//   clock  : rising-edge clock
//   reset  : asynchronous active-high reset, clears the count
//   clear  : synchronous clear (takes priority over enable)
//   enable : advance the count this cycle
//   tc     : terminal count, high while the count equals ITERS-1
module md_counter #(
  parameter int unsigned ITERS = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CntW = (ITERS > 1) ? $clog2(ITERS) : 1;

  logic [CntW-1:0] count_q, count_d;

  assign tc = (count_q == CntW'(ITERS - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = tc ? '0 : count_q + CntW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) sequencer.
//   clock, reset          : rising-edge clock, async active-high reset
//   data_operandA/B       : multiplicand/dividend, multiplier/divisor (two's complement)
//   ctrl_MULT, ctrl_DIV   : one-cycle start pulses (both high = multiply; restart aborts)
//   data_result           : low WIDTH bits of product, or quotient truncated toward zero
//   data_exception        : overflow / divide-by-zero, valid with data_resultRDY
//   data_resultRDY        : one-cycle strobe, ITERS+1 cycles after the start edge
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [4:0]       op_q, op_d;
  // acc: Booth accumulator (one guard bit) or division remainder
  logic [WIDTH:0]   acc_q, acc_d;
  // q: multiplier shifting out / dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             q1_q, q1_d;
  logic             neg_q, neg_d;
  logic             div_err_q, div_err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic             start, running, last_iter;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_a, add_b, add_sum, booth, div_shift;
  logic             add_sub;
  logic [WIDTH:0]   mul_hi;

  assign start   = ctrl_MULT | ctrl_DIV;
  assign running = (state_q == StMulRun) || (state_q == StDivRun);
  assign a_mag   = data_operandA[WIDTH-1] ? ('0 - data_operandA) : data_operandA;
  assign b_mag   = data_operandB[WIDTH-1] ? ('0 - data_operandB) : data_operandB;

  assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
  // Upper WIDTH+1 bits of the 2*WIDTH product must be a pure sign extension
  assign mul_hi    = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};

  md_counter #(
    .ITERS(ITERS)
  ) u_counter (
    .clock (clock),
    .reset (reset),
    .clear (start),
    .enable(running),
    .tc    (last_iter)
  );

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ctrl_MULT ? StMulRun : StDivRun;
    end else begin
      unique case (state_q)
        StIdle:             state_d = StIdle;
        StMulRun, StDivRun: if (last_iter) state_d = StDone;
        StDone:             state_d = StIdle;
        default:            state_d = StIdle;
      endcase
    end
  end

  // Single shared WIDTH+1-bit adder. In DONE it negates the quotient magnitude.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    unique case (state_q)
      StMulRun: begin
        add_a   = acc_q;
        add_b   = {m_q[WIDTH-1], m_q};
        add_sub = q_q[0];  // Booth pair 10 subtracts, 01 adds
      end
      StDivRun: begin
        add_a   = div_shift;
        add_b   = {1'b0, m_q};
        add_sub = 1'b1;
      end
      StDone: begin
        add_b   = {1'b0, q_q};
        add_sub = neg_q;
      end
      default: ;
    endcase
    add_sum = add_a + (add_sub ? ~add_b : add_b) + {{WIDTH{1'b0}}, add_sub};
  end

  always_comb begin
    acc_d     = acc_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    op_d      = op_q;
    neg_d     = neg_q;
    div_err_d = div_err_q;
    result_d  = result_q;
    exc_d     = exc_q;
    rdy_d     = 1'b0;
    booth     = acc_q;
    if (start) begin
      acc_d     = '0;
      q1_d      = 1'b0;
      neg_d     = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_err_d = (data_operandB == '0) || ((data_operandA == MinVal) && (data_operandB == '1));
      if (ctrl_MULT) begin
        op_d = AluOpMult;
        q_d  = data_operandB;
        m_d  = data_operandA;
      end else begin
        op_d = AluOpDiv;
        q_d  = a_mag;
        m_d  = b_mag;
      end
    end else begin
      unique case (state_q)
        StMulRun: begin
          booth = (q_q[0] ^ q1_q) ? add_sum : acc_q;
          acc_d = {booth[WIDTH], booth[WIDTH:1]};
          q_d   = {booth[0], q_q[WIDTH-1:1]};
          q1_d  = q_q[0];
        end
        StDivRun: begin
          // Negative trial difference: keep the shifted remainder
          acc_d = add_sum[WIDTH] ? div_shift : add_sum;
          q_d   = {q_q[WIDTH-2:0], ~add_sum[WIDTH]};
        end
        StDone: begin
          rdy_d = 1'b1;
          if (op_q == AluOpMult) begin
            result_d = q_q;
            exc_d    = ~((&mul_hi) | ~(|mul_hi));
          end else if (div_err_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = add_sum[WIDTH-1:0];
            exc_d    = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      q1_q      <= 1'b0;
      neg_q     <= 1'b0;
      div_err_q <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      m_q       <= m_d;
      q1_q      <= q1_d;
      neg_q     <= neg_d;
      div_err_q <= div_err_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
      rdy_q     <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: directed cases, randomized ops against a
// plain-arithmetic reference model, restart, hold, back-to-back and async reset.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  multdiv_ctrl #(
    .WIDTH(32),
    .ITERS(32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  // Reference: exact 64-bit arithmetic, SV division truncates toward zero.
  function automatic void model(input logic m, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      p = sa * sb;
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (sb == 0) begin
      r = 32'h0;
      e = 1'b1;
    end else if (sa == -64'sd2147483648 && sb == -64'sd1) begin
      r = 32'h0;
      e = 1'b1;
    end else begin
      p = sa / sb;
      r = p[31:0];
      e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(0, 40)) - 32'd20;
      2:       v = corners[$urandom_range(0, 4)];
      default: begin
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = 32'd0 - v;
      end
    endcase
    return v;
  endfunction

  // Pulse a start, scramble operands afterwards, wait (bounded) for the strobe.
  // lat is the number of rising edges after the start edge (-1 on timeout).
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc, output int lat,
                        output logic rdy_after);
    @(negedge clock);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    res = data_result;
    exc = data_exception;
    @(posedge clock);
    #1;
    rdy_after = data_resultRDY;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = 32'h0;
    data_operandB = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if ({data_result, data_exception, data_resultRDY} !== 34'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got result=%h exc=%b rdy=%b, want all zero",
               data_result, data_exception, data_resultRDY);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (data_resultRDY !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_no_rdy: got rdy=%b, want 0", data_resultRDY);
    end
  endtask

  task automatic test_directed();
    logic        op_m   [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 1};
    logic [31:0] op_a   [9] = '{32'd7, 32'h0001_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF9, 32'd100,
                                32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] op_b   [9] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'd2, 32'd7,
                                32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] want_r [9] = '{32'hFFFF_FFEB, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'd14,
                                32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000};
    logic        want_e [9] = '{0, 1, 0, 0, 0, 1, 1, 0, 1};
    logic [31:0] res;
    logic        exc, rdy_after;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      run_op(op_m[i], ~op_m[i], op_a[i], op_b[i], res, exc, lat, rdy_after);
      tests_run += 4;
      if (res !== want_r[i]) begin
        tests_failed++;
        $display("FAIL directed_result[%0d]: got %h, want %h", i, res, want_r[i]);
      end
      if (exc !== want_e[i]) begin
        tests_failed++;
        $display("FAIL directed_exc[%0d]: got %b, want %b", i, exc, want_e[i]);
      end
      if (lat != 33) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got %0d, want 33", i, lat);
      end
      if (rdy_after !== 1'b0) begin
        tests_failed++;
        $display("FAIL directed_rdy_drop[%0d]: got %b, want 0", i, rdy_after);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, res, exp_r;
    logic        m, d, exc, exp_e, rdy_after;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      a = pick_operand();
      b = pick_operand();
      m = 1'($urandom_range(0, 1));
      d = m ? 1'($urandom_range(0, 1)) : 1'b1;
      model(m, a, b, exp_r, exp_e);
      run_op(m, d, a, b, res, exc, lat, rdy_after);
      tests_run += 3;
      if (res !== exp_r || exc !== exp_e) begin
        tests_failed++;
        $display("FAIL random[%0d] %s %h,%h: got %h/%b, want %h/%b", i, m ? "mul" : "div",
                 a, b, res, exc, exp_r, exp_e);
      end
      if (lat != 33) begin
        tests_failed++;
        $display("FAIL random_latency[%0d]: got %0d, want 33", i, lat);
      end
      if (rdy_after !== 1'b0) begin
        tests_failed++;
        $display("FAIL random_rdy_drop[%0d]: got %b, want 0", i, rdy_after);
      end
    end
  endtask

  task automatic test_restart();
    logic early;
    int   lat;
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    early = 1'b0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early = 1'b1;
    end
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd20;
    data_operandB = 32'd5;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    tests_run += 3;
    if (early !== 1'b0 || lat != 33) begin
      tests_failed++;
      $display("FAIL restart_latency: got early=%b lat=%0d, want early=0 lat=33", early, lat);
    end
    if (data_result !== 32'd4) begin
      tests_failed++;
      $display("FAIL restart_result: got %h, want 00000004", data_result);
    end
    if (data_exception !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_exc: got %b, want 0", data_exception);
    end
  endtask

  task automatic test_both_ctrl();
    logic [31:0] res;
    logic        exc, rdy_after;
    int          lat;
    run_op(1'b1, 1'b1, 32'd2, 32'd3, res, exc, lat, rdy_after);
    tests_run += 2;
    if (res !== 32'd6 || exc !== 1'b0) begin
      tests_failed++;
      $display("FAIL both_ctrl_result: got %h/%b, want 00000006/0", res, exc);
    end
    if (lat != 33) begin
      tests_failed++;
      $display("FAIL both_ctrl_latency: got %0d, want 33", lat);
    end
  endtask

  task automatic test_hold();
    logic [31:0] res;
    logic        exc, rdy_after, changed;
    int          lat;
    run_op(1'b1, 1'b0, 32'h4000_0000, 32'd4, res, exc, lat, rdy_after);  // overflow: 0/1
    run_op(1'b1, 1'b0, 32'd6, 32'hFFFF_FFF9, res, exc, lat, rdy_after);  // -42/0
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd0;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    changed = 1'b0;
    repeat (32) begin
      @(posedge clock);
      #1;
      if (data_result !== 32'hFFFF_FFD6 || data_exception !== 1'b0 || data_resultRDY !== 1'b0)
        changed = 1'b1;
    end
    @(posedge clock);
    #1;
    tests_run += 2;
    if (changed !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_during_run: got changed=%b, want 0", changed);
    end
    if (data_resultRDY !== 1'b1 || data_result !== 32'h0 || data_exception !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_div0_done: got rdy=%b %h/%b, want rdy=1 00000000/1",
               data_resultRDY, data_result, data_exception);
    end
    @(posedge clock);
  endtask

  task automatic test_back_to_back();
    logic [31:0] first_r;
    int          lat;
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd5;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    first_r = data_result;
    // Start the next op in the strobe cycle itself
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = 32'd50;
    data_operandB = 32'hFFFF_FFFB;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    tests_run += 2;
    if (lat != 33 || first_r !== 32'd25) begin
      tests_failed++;
      $display("FAIL b2b_first: got lat=%0d res=%h, want lat=33 res=00000019", lat, first_r);
    end
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = i;
        break;
      end
    end
    if (lat != 33 || data_result !== 32'hFFFF_FFF6) begin
      tests_failed++;
      $display("FAIL b2b_second: got lat=%0d res=%h, want lat=33 res=fffffff6", lat, data_result);
    end
    @(posedge clock);
  endtask

  task automatic test_async_reset();
    logic [31:0] res;
    logic        exc, rdy_after, seen;
    int          lat;
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (14) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    tests_run++;
    if ({data_result, data_exception, data_resultRDY} !== 34'h0) begin
      tests_failed++;
      $display("FAIL async_reset_outputs: got %h/%b rdy=%b, want zero",
               data_result, data_exception, data_resultRDY);
    end
    #2;
    reset = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_no_rdy: got rdy seen=%b, want 0", seen);
    end
    run_op(1'b1, 1'b0, 32'd2, 32'd2, res, exc, lat, rdy_after);
    tests_run++;
    if (res !== 32'd4 || exc !== 1'b0 || lat != 33) begin
      tests_failed++;
      $display("FAIL post_reset_mult: got %h/%b lat=%0d, want 00000004/0 lat=33", res, exc, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_restart();
    test_both_ctrl();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
